// File: rtl/watch_pkg.sv
// -----------------------------------------------------------------------------
// watch_pkg
// Shared definitions for the watch time report transmitter:
//   - tx_state_e    : report FSM state encoding (IDLE, LOAD, SEND, WAIT)
//   - ASCII_*       : characters used to build the "HH:MM:SS.CC" line
//   - LINE_LEN_*    : line lengths with CR LF or with LF only
//   - time_snap_t   : snapshot of the four time fields taken at report start
// -----------------------------------------------------------------------------
package watch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT
    } tx_state_e;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int LINE_LEN_CRLF = 13;
    localparam int LINE_LEN_LF   = 12;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] msec;
    } time_snap_t;

endpackage

// File: rtl/watch_time_tx_if.sv
// -----------------------------------------------------------------------------
// watch_time_tx_if
// Byte handshake between the report serializer and uart_tx.
//   tx_data  : byte to transmit (serializer -> uart)
//   tx_start : one-cycle launch pulse for tx_data (serializer -> uart)
//   tx_done  : one-cycle pulse when the byte's stop bit completes (uart -> serializer)
// Modports: master = serializer side, slave = uart_tx side.
// -----------------------------------------------------------------------------
interface watch_time_tx_if;

    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;

    modport master (output tx_data, output tx_start, input tx_done);
    modport slave  (input tx_data, input tx_start, output tx_done);

endinterface

// File: rtl/watch_time_tx_bin2digits.sv
// -----------------------------------------------------------------------------
// bin2digits
// Combinational split of a 7-bit value into decimal tens and ones digits.
// Values above 99 saturate to 9/9 so an out-of-range field still prints
// as two digits.
//   value : 7-bit binary input
//   tens  : tens digit, 0..9
//   ones  : ones digit, 0..9
// -----------------------------------------------------------------------------
module bin2digits (
    input  logic [6:0] value,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [6:0] sat;

    // NOTE: every variable assigned here gets a value on every path, so no
    // latch is inferred.
    always_comb begin
        sat  = (value > 7'd99) ? 7'd99 : value;
        tens = 4'(sat / 7'd10);
        ones = 4'(sat - 7'd10 * {3'b000, tens});
    end

endmodule

// File: rtl/watch_time_tx.sv
// -----------------------------------------------------------------------------
// watch_time_tx
// Serializes a snapshot of the watch time as "HH:MM:SS.CC" + CR LF (or LF
// only) and hands it byte by byte to uart_tx. The time is captured when a
// report starts, so the line stays coherent while the counters run on.
//
// Parameters:
//   TERM_CRLF : 1 -> line ends CR LF (13 bytes); 0 -> LF only (12 bytes)
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   msec/sec/min/hour : live time fields
//   send_req  : one-cycle request for one report line
//   tx        : byte handshake to uart_tx (master side)
//   o_busy    : high from report start until the last byte's tx_done
// Configuration:
//   WATCH_TX_AUTO_EN : when defined, any change of sec also triggers a report
// -----------------------------------------------------------------------------
module watch_time_tx
    import watch_pkg::*;
#(
    parameter int TERM_CRLF = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             msec,
    input  logic [5:0]             sec,
    input  logic [5:0]             min,
    input  logic [4:0]             hour,
    input  logic                   send_req,
    watch_time_tx_if.master        tx,
    output logic                   o_busy
);

    localparam logic [3:0] LAST_IDX = (TERM_CRLF != 0) ? 4'(LINE_LEN_CRLF - 1)
                                                       : 4'(LINE_LEN_LF - 1);

    tx_state_e  state_q, state_d;
    logic [3:0] idx_q, idx_d;
    time_snap_t snap_q, snap_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;
    logic       busy_q, busy_d;

    logic       trigger;
    logic [6:0] field;
    logic [3:0] tens, ones;
    logic [7:0] char_sel;

`ifdef WATCH_TX_AUTO_EN
    // Registered copy of sec; any difference means the second moved (or was
    // edited), which raises a one-cycle auto trigger.
    logic [5:0] sec_copy_q, sec_copy_d;
    logic       auto_trig;

    assign sec_copy_d = sec;
    assign auto_trig  = (sec != sec_copy_q);
    assign trigger    = send_req | auto_trig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sec_copy_q <= '0;
        else     sec_copy_q <= sec_copy_d;
    end
`else
    assign trigger = send_req;
`endif

    // One digit converter shared by all fields: pick the field this index
    // belongs to, then choose tens or ones below.
    always_comb begin
        field = '0;
        case (idx_q)
            4'd0,  4'd1:  field = {2'b00, snap_q.hour};
            4'd3,  4'd4:  field = {1'b0, snap_q.min};
            4'd6,  4'd7:  field = {1'b0, snap_q.sec};
            4'd9,  4'd10: field = snap_q.msec;
            default:      field = '0;
        endcase
    end

    bin2digits u_bin2digits (
        .value (field),
        .tens  (tens),
        .ones  (ones)
    );

    always_comb begin
        char_sel = 8'h00;
        case (idx_q)
            4'd0, 4'd3, 4'd6, 4'd9:  char_sel = ASCII_0 + {4'b0000, tens};
            4'd1, 4'd4, 4'd7, 4'd10: char_sel = ASCII_0 + {4'b0000, ones};
            4'd2, 4'd5:              char_sel = ASCII_COLON;
            4'd8:                    char_sel = ASCII_DOT;
            4'd11:                   char_sel = (TERM_CRLF != 0) ? ASCII_CR : ASCII_LF;
            4'd12:                   char_sel = ASCII_LF;
            default:                 char_sel = 8'h00;
        endcase
    end

    // Next-state logic. tx_start defaults low so it can only ever be a
    // single-cycle pulse out of SEND. Triggers outside IDLE are dropped.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    snap_d.hour = hour;
                    snap_d.min  = min;
                    snap_d.sec  = sec;
                    snap_d.msec = msec;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                tx_data_d = char_sel;
                state_d   = SEND;
            end
            SEND: begin
                tx_start_d = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (tx.tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            snap_q     <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_start = tx_start_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_watch_time_tx.sv
// -----------------------------------------------------------------------------
// tb_watch_time_tx
// Self-checking bench for watch_time_tx: a CR LF instance and an LF-only
// instance, each acknowledged by a small uart_tx stand-in. Expected lines are
// formatted directly from the time values with $sformatf.
// -----------------------------------------------------------------------------
module tb_watch_time_tx;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       send_req;
    logic       send_req_b;
    logic       busy_a;
    logic       busy_b;

    watch_time_tx_if bus_a ();
    watch_time_tx_if bus_b ();

    watch_time_tx dut (
        .clk      (clk),
        .rst      (rst),
        .msec     (msec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .send_req (send_req),
        .tx       (bus_a),
        .o_busy   (busy_a)
    );

    watch_time_tx #(.TERM_CRLF(0)) dut_lf (
        .clk      (clk),
        .rst      (rst),
        .msec     (msec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .send_req (send_req_b),
        .tx       (bus_b),
        .o_busy   (busy_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- uart_tx stand-ins ----------------
    int   ack_dly = 20;
    bq_t  a_bytes;
    int   a_starts = 0;
    int   a_done_cyc = 0;
    bq_t  b_bytes;
    int   b_starts = 0;

    initial begin
        bus_a.tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus_a.tx_start === 1'b1) begin
                a_bytes.push_back(bus_a.tx_data);
                a_starts++;
                repeat (ack_dly) @(posedge clk);
                #1 bus_a.tx_done = 1'b1;
                a_done_cyc = cyc;
                @(posedge clk); #1 bus_a.tx_done = 1'b0;
            end
        end
    end

    initial begin
        bus_b.tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus_b.tx_start === 1'b1) begin
                b_bytes.push_back(bus_b.tx_data);
                b_starts++;
                repeat (5) @(posedge clk);
                #1 bus_b.tx_done = 1'b1;
                @(posedge clk); #1 bus_b.tx_done = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int sat99(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    function automatic bq_t model_line(input int h, input int m, input int s, input int c,
                                       input bit crlf);
        string str;
        bq_t   q;
        str = $sformatf("%02d:%02d:%02d.%02d", sat99(h), sat99(m), sat99(s), sat99(c));
        for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
        if (crlf) q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    // ---------------- helpers ----------------
    task automatic check_line(input string tag, input bq_t got, input bq_t exp);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s_b%0d", tag, i),
                  (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp[i]));
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        @(posedge clk); #1 send_req = 1'b0;
    endtask

    // Entered while busy_a is high; also checks that busy fell on the edge
    // right after the last tx_done.
    task automatic wait_idle_a(input string tag);
        int n = 0;
        while (busy_a !== 1'b0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_idle_timeout"}, n < 2000, 1);
        check({tag, "_busy_fall_cyc"}, cyc, a_done_cyc + 1);
    endtask

    task automatic wait_busy_a(input string tag);
        int n = 0;
        while (busy_a !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_busy_timeout"}, n < 50, 1);
    endtask

    task automatic wait_starts_a(input string tag, input int target);
        int n = 0;
        while (a_starts < target && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_start_timeout"}, n < 2000, 1);
    endtask

    task automatic set_time(input int h, input int m, input int s, input int c);
        hour = 5'(h);
        min  = 6'(m);
        sec  = 6'(s);
        msec = 7'(c);
    endtask

    task automatic clear_a();
        a_bytes.delete();
        a_starts = 0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int h, m, s, c;
        int n;

        rst        = 1'b1;
        send_req   = 1'b0;
        send_req_b = 1'b0;
        set_time(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_data", bus_a.tx_data, 8'h00);
        check("rst_tx_start", bus_a.tx_start, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef WATCH_TX_AUTO_EN
        // Auto trigger: settle sec at 10 (one line), then step 10->11->12.
        set_time(1, 2, 0, 3);
        sec = 6'd10;
        wait_busy_a("auto_pre");
        wait_idle_a("auto_pre");
        clear_a();
        sec = 6'd11;
        @(posedge clk); #1 sec = 6'd12;
        @(posedge clk); #1;
        wait_idle_a("auto1");
        check_line("auto1", a_bytes, model_line(1, 2, 11, 3, 1'b1));
        check("auto1_starts", a_starts, 13);
        repeat (10) @(posedge clk);
        #1;
        check("auto_no_queue", busy_a, 1'b0);
        clear_a();
        sec = 6'd13;
        wait_busy_a("auto2");
        wait_idle_a("auto2");
        check_line("auto2", a_bytes, model_line(1, 2, 13, 3, 1'b1));
`else
        // First line: latency and content of 12:00:00.00.
        set_time(12, 0, 0, 0);
        clear_a();
        pulse_req();
        check("lat_busy_n1", busy_a, 1'b1);
        check("lat_start_n1", bus_a.tx_start, 1'b0);
        @(posedge clk); #1;
        check("lat_data_n2", bus_a.tx_data, 8'h31);
        check("lat_start_n2", bus_a.tx_start, 1'b0);
        @(posedge clk); #1;
        check("lat_start_n3", bus_a.tx_start, 1'b1);
        @(posedge clk); #1;
        check("lat_start_n4", bus_a.tx_start, 1'b0);
        wait_idle_a("line1");
        check_line("line1", a_bytes, model_line(12, 0, 0, 0, 1'b1));
        check("line1_starts", a_starts, 13);

        // Snapshot coherence across a midnight rollover of the inputs.
        set_time(23, 59, 59, 99);
        clear_a();
        pulse_req();
        wait_starts_a("wrap", 3);
        set_time(0, 0, 0, 0);
        wait_idle_a("wrap");
        check_line("wrap", a_bytes, model_line(23, 59, 59, 99, 1'b1));

        // Requests while busy are dropped.
        set_time(8, 30, 15, 42);
        clear_a();
        pulse_req();
        repeat (4) @(posedge clk);
        #1;
        pulse_req();
        repeat (44) @(posedge clk);
        #1;
        pulse_req();
        wait_idle_a("drop");
        check_line("drop", a_bytes, model_line(8, 30, 15, 42, 1'b1));
        repeat (30) @(posedge clk);
        #1;
        check("drop_no_extra_starts", a_starts, 13);
        check("drop_idle", busy_a, 1'b0);

        // Randomized lines; each new request lands right after busy falls,
        // and the inputs move mid-line.
        for (int k = 0; k < 6; k++) begin
            h = int'($urandom_range(0, 31));
            m = int'($urandom_range(0, 63));
            s = int'($urandom_range(0, 63));
            c = int'($urandom_range(0, 127));
            ack_dly = int'($urandom_range(1, 25));
            set_time(h, m, s, c);
            clear_a();
            pulse_req();
            check($sformatf("rnd%0d_accept", k), busy_a, 1'b1);
            n = int'($urandom_range(1, 12));
            wait_starts_a($sformatf("rnd%0d", k), n);
            set_time(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 63)), int'($urandom_range(0, 127)));
            wait_idle_a($sformatf("rnd%0d", k));
            check_line($sformatf("rnd%0d", k), a_bytes, model_line(h, m, s, c, 1'b1));
        end
        ack_dly = 20;

        // LF-only instance.
        set_time(3, 7, 9, 5);
        b_bytes.delete();
        b_starts = 0;
        send_req_b = 1'b1;
        @(posedge clk); #1 send_req_b = 1'b0;
        check("lf_busy", busy_b, 1'b1);
        n = 0;
        while (busy_b !== 1'b0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("lf_idle_timeout", n < 2000, 1);
        check_line("lf", b_bytes, model_line(3, 7, 9, 5, 1'b0));
        check("lf_starts", b_starts, 12);

        // Reset in the middle of a line aborts it.
        set_time(17, 45, 3, 60);
        clear_a();
        pulse_req();
        wait_starts_a("rst_mid", 6);
        rst = 1'b1;
        #1;
        check("rst_mid_tx_start", bus_a.tx_start, 1'b0);
        check("rst_mid_busy", busy_a, 1'b0);
        check("rst_mid_tx_data", bus_a.tx_data, 8'h00);
        @(posedge clk); #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("rst_mid_stays_idle", busy_a, 1'b0);
        set_time(4, 5, 6, 7);
        clear_a();
        pulse_req();
        wait_idle_a("after_rst");
        check_line("after_rst", a_bytes, model_line(4, 5, 6, 7, 1'b1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
